// File: rtl/pulse_sequencer.sv
// pulse_sequencer: steps one pulse_generator through a small table of
// (delay, width, repetition) entries over its start/ack handshake, optionally looping.
module pulse_sequencer #(
  parameter  int N_ENTRIES = 8,
  parameter  int DELAY_W   = 32,
  parameter  int PWIDTH_W  = 32,
  parameter  int REP_W     = 16,
  localparam int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_addr,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic [PWIDTH_W-1:0] cfg_width,
  input  logic [REP_W-1:0]    cfg_rep,
  input  logic [IDX_W:0]      num_entries,
  input  logic                loop_en,
  input  logic                seq_start,
  input  logic                seq_stop,
  output logic                pg_start,
  output logic [DELAY_W-1:0]  pg_delay_cycles,
  output logic [PWIDTH_W-1:0] pg_pulse_width,
  output logic [REP_W-1:0]    pg_repetition,
  output logic                pg_abort,
  input  logic                pg_start_ack,
  input  logic                pg_idle,
  output logic                busy,
  output logic [IDX_W-1:0]    cur_index,
  output logic [15:0]         loop_count,
  output logic                seq_done,
  output logic                cfg_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_START, ST_RUN, ST_NEXT} state_t;

  localparam logic [IDX_W:0] MAX_ENTRIES = (IDX_W+1)'(N_ENTRIES);

  state_t              state;
  logic [DELAY_W-1:0]  tbl_delay [N_ENTRIES];
  logic [PWIDTH_W-1:0] tbl_width [N_ENTRIES];
  logic [REP_W-1:0]    tbl_rep   [N_ENTRIES];
  logic [IDX_W:0]      num_lat;
  logic                loop_lat;
  logic                first_run;
  logic [IDX_W:0]      next_index;
  logic                num_ok;

  assign next_index = {1'b0, cur_index} + (IDX_W+1)'(1);
  assign num_ok     = (num_entries != '0) && (num_entries <= MAX_ENTRIES);

  // The table has no reset; entries are only meaningful once written.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      tbl_delay[cfg_addr] <= cfg_delay;
      tbl_width[cfg_addr] <= cfg_width;
      tbl_rep[cfg_addr]   <= cfg_rep;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      pg_start        <= 1'b0;
      pg_delay_cycles <= '0;
      pg_pulse_width  <= '0;
      pg_repetition   <= '0;
      pg_abort        <= 1'b0;
      busy            <= 1'b0;
      cur_index       <= '0;
      loop_count      <= '0;
      seq_done        <= 1'b0;
      cfg_err         <= 1'b0;
      num_lat         <= '0;
      loop_lat        <= 1'b0;
      first_run       <= 1'b0;
    end else begin
      pg_abort <= 1'b0;
      seq_done <= 1'b0;
      // An abort outranks everything, including an ack arriving in the same cycle.
      if (state != ST_IDLE && seq_stop) begin
        pg_abort <= 1'b1;
        pg_start <= 1'b0;
        busy     <= 1'b0;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (seq_start && !seq_stop) begin
              if (num_ok) begin
                num_lat    <= num_entries;
                loop_lat   <= loop_en;
                cur_index  <= '0;
                loop_count <= '0;
                cfg_err    <= 1'b0;
                busy       <= 1'b1;
                state      <= ST_LOAD;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            pg_delay_cycles <= tbl_delay[cur_index];
            pg_pulse_width  <= tbl_width[cur_index];
            // rep==0 would put the generator in infinite mode; issue a single pulse instead.
            if (tbl_rep[cur_index] == '0) begin
              pg_repetition <= REP_W'(1);
              cfg_err       <= 1'b1;
            end else begin
              pg_repetition <= tbl_rep[cur_index];
            end
            pg_start <= 1'b1;
            state    <= ST_START;
          end
          ST_START: begin
            if (pg_start_ack) begin
              pg_start  <= 1'b0;
              first_run <= 1'b1;
              state     <= ST_RUN;
            end
          end
          ST_RUN: begin
            // The generator may still report idle in the cycle right after the ack.
            if (first_run) begin
              first_run <= 1'b0;
            end else if (pg_idle) begin
              state <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (next_index < num_lat) begin
              cur_index <= next_index[IDX_W-1:0];
              state     <= ST_LOAD;
            end else begin
              if (loop_count != 16'hFFFF) loop_count <= loop_count + 16'd1;
              if (loop_lat) begin
                cur_index <= '0;
                state     <= ST_LOAD;
              end else begin
                seq_done <= 1'b1;
                busy     <= 1'b0;
                state    <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: directed checks of pulse_sequencer against a small
// behavioural pulse_generator stand-in that acks and runs for fixed cycle counts.
module tb_pulse_sequencer;

  localparam int N_ENTRIES = 8;
  localparam int DELAY_W   = 32;
  localparam int PWIDTH_W  = 32;
  localparam int REP_W     = 16;
  localparam int IDX_W     = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                cfg_we = 1'b0;
  logic [IDX_W-1:0]    cfg_addr = '0;
  logic [DELAY_W-1:0]  cfg_delay = '0;
  logic [PWIDTH_W-1:0] cfg_width = '0;
  logic [REP_W-1:0]    cfg_rep = '0;
  logic [IDX_W:0]      num_entries = '0;
  logic                loop_en = 1'b0;
  logic                seq_start = 1'b0;
  logic                seq_stop = 1'b0;
  logic                pg_start;
  logic [DELAY_W-1:0]  pg_delay_cycles;
  logic [PWIDTH_W-1:0] pg_pulse_width;
  logic [REP_W-1:0]    pg_repetition;
  logic                pg_abort;
  logic                pg_start_ack = 1'b0;
  logic                pg_idle = 1'b1;
  logic                busy;
  logic [IDX_W-1:0]    cur_index;
  logic [15:0]         loop_count;
  logic                seq_done;
  logic                cfg_err;

  int errors = 0;
  int checks = 0;

  int ack_delay = 0;
  int run_len   = 2;
  int phase     = 0;
  int gcnt      = 0;
  int log_n     = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;
  int cyc;

  logic [IDX_W-1:0]    log_idx   [64];
  logic [DELAY_W-1:0]  log_delay [64];
  logic [PWIDTH_W-1:0] log_width [64];
  logic [REP_W-1:0]    log_rep   [64];
  logic [15:0]         log_loop  [64];
  int                  log_slen  [64];

  pulse_sequencer #(
    .N_ENTRIES(N_ENTRIES), .DELAY_W(DELAY_W), .PWIDTH_W(PWIDTH_W), .REP_W(REP_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay),
    .cfg_width(cfg_width), .cfg_rep(cfg_rep),
    .num_entries(num_entries), .loop_en(loop_en),
    .seq_start(seq_start), .seq_stop(seq_stop),
    .pg_start(pg_start), .pg_delay_cycles(pg_delay_cycles),
    .pg_pulse_width(pg_pulse_width), .pg_repetition(pg_repetition),
    .pg_abort(pg_abort), .pg_start_ack(pg_start_ack), .pg_idle(pg_idle),
    .busy(busy), .cur_index(cur_index), .loop_count(loop_count),
    .seq_done(seq_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Generator stand-in: acks after ack_delay extra cycles, stays idle one cycle past
  // the ack, then is busy for run_len cycles; logs what was issued at each ack.
  initial begin
    forever begin
      @(negedge clk);
      if (seq_done === 1'b1) done_cnt++;
      if (pg_abort === 1'b1) abort_cnt++;
      if (busy !== 1'b1) begin
        phase = 0; gcnt = 0; pg_start_ack = 1'b0; pg_idle = 1'b1;
      end else begin
        case (phase)
          0: if (pg_start === 1'b1) begin
               if (gcnt == ack_delay) begin
                 pg_start_ack     = 1'b1;
                 log_idx[log_n]   = cur_index;
                 log_delay[log_n] = pg_delay_cycles;
                 log_width[log_n] = pg_pulse_width;
                 log_rep[log_n]   = pg_repetition;
                 log_loop[log_n]  = loop_count;
                 log_slen[log_n]  = gcnt + 1;
                 if (log_n < 63) log_n++;
                 phase = 1; gcnt = 0;
               end else begin
                 gcnt++;
               end
             end
          1: begin pg_start_ack = 1'b0; phase = 2; end
          2: begin pg_idle = 1'b0; gcnt = 0; phase = 3; end
          default: begin
            if (gcnt == run_len - 1) begin
              pg_idle = 1'b1; phase = 0; gcnt = 0;
            end else begin
              gcnt++;
            end
          end
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic stop);
    seq_start = start;
    seq_stop  = stop;
    @(negedge clk);
    seq_start = 1'b0;
    seq_stop  = 1'b0;
  endtask

  task automatic writeEntry(input int addr, input int d, input int w, input int r);
    cfg_we    = 1'b1;
    cfg_addr  = IDX_W'(addr);
    cfg_delay = DELAY_W'(d);
    cfg_width = PWIDTH_W'(w);
    cfg_rep   = REP_W'(r);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic waitDone(input int from, input int budget, output int n);
    n = from;
    while (seq_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitIssues(input int k, input int budget);
    int c = 0;
    while (log_n < k && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic clearLogs();
    log_n = 0; done_cnt = 0; abort_cnt = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset flags", {pg_start, pg_abort, busy, seq_done, cfg_err, cur_index, loop_count}, 0);
    checkOutput("reset pg fields", {pg_delay_cycles, pg_pulse_width}, 0);
    checkOutput("reset pg rep", pg_repetition, 0);
    reset = 1'b0;
    writeEntry(0, 10, 20, 2);
    writeEntry(1, 5, 5, 1);

    // Two-entry single pass.
    clearLogs();
    ack_delay = 0; run_len = 2; num_entries = 2; loop_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1 busy after start", busy, 1);
    checkOutput("t1 no early pg_start", pg_start, 0);
    @(negedge clk);
    checkOutput("t1 pg_start latency", pg_start, 1);
    waitDone(1, 200, cyc);
    checkOutput("t1 cycles to done", cyc, 14);
    checkOutput("t1 busy at done", busy, 0);
    checkOutput("t1 loop_count", loop_count, 1);
    checkOutput("t1 issue count", log_n, 2);
    checkOutput("t1 entry0", {log_idx[0], log_delay[0], log_width[0], log_rep[0]}, {3'd0, 32'd10, 32'd20, 16'd2});
    checkOutput("t1 entry1", {log_idx[1], log_delay[1], log_width[1], log_rep[1]}, {3'd1, 32'd5, 32'd5, 16'd1});
    checkOutput("t1 start len", log_slen[0], 1);
    @(negedge clk);
    checkOutput("t1 seq_done pulse", seq_done, 0);
    checkOutput("t1 done count", done_cnt, 1);

    // Looping; loop_en is dropped after start and must not matter.
    clearLogs();
    loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    loop_en = 1'b0;
    waitIssues(6, 300);
    checkOutput("t2 issues reached", (log_n >= 6), 1);
    checkOutput("t2 issue2", {log_idx[2], log_loop[2]}, {3'd0, 16'd1});
    checkOutput("t2 issue3", {log_idx[3], log_loop[3]}, {3'd1, 16'd1});
    checkOutput("t2 issue4", {log_idx[4], log_loop[4], log_delay[4]}, {3'd0, 16'd2, 32'd10});
    checkOutput("t2 issue5", {log_idx[5], log_loop[5]}, {3'd1, 16'd2});
    checkOutput("t2 no seq_done", done_cnt, 0);

    // Abort during RUN of entry 1.
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3 abort pulse", pg_abort, 1);
    checkOutput("t3 idle after stop", {busy, pg_start, seq_done}, 0);
    @(negedge clk);
    checkOutput("t3 abort one cycle", pg_abort, 0);
    checkOutput("t3 counts", {done_cnt[7:0], abort_cnt[7:0]}, {8'd0, 8'd1});

    // Start and stop together in IDLE: stop wins, start dropped.
    clearLogs();
    num_entries = 2;
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3 start+stop idle", {busy, pg_abort}, 0);
    @(negedge clk);
    checkOutput("t3 start+stop no issue", {busy, pg_start}, 0);

    // Bad num_entries and rep==0.
    num_entries = 0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4 n=0 cfg_err", {cfg_err, busy}, 2'b10);
    @(negedge clk);
    checkOutput("t4 n=0 no pg_start", {pg_start, busy}, 0);
    num_entries = 9;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4 n=9 cfg_err", {cfg_err, busy, pg_start}, 3'b100);
    writeEntry(0, 10, 20, 0);
    num_entries = 1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4 cfg_err cleared", {cfg_err, busy}, 2'b01);
    @(negedge clk);
    checkOutput("t4 rep0 issue", {pg_start, cfg_err, pg_repetition}, {1'b1, 1'b1, 16'd1});
    waitDone(1, 100, cyc);
    checkOutput("t4 single entry cycles", cyc, 7);
    writeEntry(0, 10, 20, 2);

    // Slow ack, plus a table write while entry 0 is running.
    clearLogs();
    ack_delay = 6; num_entries = 2; loop_en = 1'b1;
    applyStimulus(1'b1, 1'b0);
    waitIssues(1, 100);
    checkOutput("t5 first issue", (log_n >= 1), 1);
    checkOutput("t5 start held", log_slen[0], 7);
    writeEntry(0, 99, 20, 2);
    waitIssues(3, 200);
    checkOutput("t5 third issue", (log_n >= 3), 1);
    checkOutput("t5 old value kept", log_delay[0], 10);
    checkOutput("t5 entry1 order", {log_idx[1], log_delay[1]}, {3'd1, 32'd5});
    checkOutput("t5 new value", {log_idx[2], log_delay[2]}, {3'd0, 32'd99});
    checkOutput("t5 no seq_done", done_cnt, 0);
    applyStimulus(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    writeEntry(0, 10, 20, 2);

    // Reset mid-START, then a fresh run.
    clearLogs();
    num_entries = 2; loop_en = 1'b0;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t6 in START", pg_start, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("t6 flags after reset", {pg_start, pg_abort, busy, seq_done, cfg_err, cur_index, loop_count}, 0);
    checkOutput("t6 pg fields after reset", {pg_delay_cycles, pg_pulse_width}, 0);
    @(negedge clk);
    checkOutput("t6 no abort on reset", abort_cnt, 0);
    clearLogs();
    ack_delay = 0;
    applyStimulus(1'b1, 1'b0);
    waitDone(0, 200, cyc);
    checkOutput("t6 fresh run cycles", cyc, 14);
    checkOutput("t6 fresh loop_count", loop_count, 1);
    checkOutput("t6 fresh issues", {log_n[7:0], log_delay[1]}, {8'd2, 32'd5});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
